// File: rtl/sim_harness_pkg.sv
// rtl/sim_harness_pkg.sv - shared state encoding and exit codes for the simulation harness controller
package sim_harness_pkg;

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      RUN     = 2'd1,
      DONE    = 2'd2,
      TIMEOUT = 2'd3
   } state_t;

   localparam logic [7:0] EXIT_TIMEOUT = 8'hFF;
   localparam logic [7:0] EXIT_PASS    = 8'h00;

   // A zero-length reset hold still needs one HOLD cycle to leave reset cleanly.
   function automatic int hold_len(input int n);
      return (n < 1) ? 1 : n;
   endfunction

endpackage

// File: rtl/sim_harness_reset_sync.sv
// rtl/sim_harness_reset_sync.sv - 2-flop async-assert / sync-deassert reset synchronizer
module reset_sync (
   input  logic clock,
   input  logic reset_n,
   output logic rst_n
);

   logic meta;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         meta  <= 1'b0;
         rst_n <= 1'b0;
      end else begin
         meta  <= 1'b1;
         rst_n <= meta;
      end
   end

endmodule

// File: rtl/sim_harness_ctrl.sv
// rtl/sim_harness_ctrl.sv - sequences DUT reset, counts run cycles, watchdog and done handshake
// Optional heartbeat output enabled by defining HARNESS_HEARTBEAT_EN.
module sim_harness_ctrl
   import sim_harness_pkg::*;
#(
   parameter int RESET_CYCLES   = 5,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int CNT_W          = 32,
   parameter int HB_LOG2        = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   output logic             dut_reset,
   input  logic             dut_done_valid,
   input  logic [7:0]       dut_done_code,
   output logic             dut_done_ready,
   output logic [CNT_W-1:0] cycle_count,
   output logic             finish,
   output logic             pass,
   output logic [7:0]       exit_code
`ifdef HARNESS_HEARTBEAT_EN
   ,
   output logic             heartbeat
`endif
);

   localparam int                HOLD_N       = hold_len(RESET_CYCLES);
   localparam int                HOLD_W       = (HOLD_N > 1) ? $clog2(HOLD_N) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(HOLD_N - 1);
   localparam bit                TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0]  TIMEOUT_LAST = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   if (HB_LOG2 < 1 || HB_LOG2 > CNT_W) begin : g_bad_hb
      $error("HB_LOG2 must be in 1..CNT_W");
   end

   logic              rst_n;
   state_t            state;
   state_t            state_next;
   logic [HOLD_W-1:0] hold_cnt;
   logic              fire;
   logic              timeout_hit;
   logic              cnt_sat;

   reset_sync u_reset_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .rst_n   (rst_n)
   );

   assign cnt_sat = &cycle_count;

   always_comb begin
      state_next  = state;
      fire        = (state == RUN) && dut_done_valid && dut_done_ready;
      timeout_hit = TIMEOUT_EN && (state == RUN) && (cycle_count == TIMEOUT_LAST);
      case (state)
         HOLD: begin
            if (hold_cnt == HOLD_LAST) state_next = RUN;
         end
         RUN: begin
            // Handshake takes priority over the watchdog on the same cycle.
            if (fire)             state_next = DONE;
            else if (timeout_hit) state_next = TIMEOUT;
         end
         default: state_next = state;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state          <= HOLD;
         hold_cnt       <= '0;
         dut_reset      <= 1'b1;
         dut_done_ready <= 1'b0;
         cycle_count    <= '0;
         finish         <= 1'b0;
         pass           <= 1'b0;
         exit_code      <= '0;
      end else begin
         state          <= state_next;
         // Registered decode of the next state keeps these glitch-free toward the DUT.
         dut_reset      <= (state_next == HOLD);
         dut_done_ready <= (state_next == RUN);
         if (state == HOLD && hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + HOLD_W'(1);
         if (state == RUN && !cnt_sat) cycle_count <= cycle_count + CNT_W'(1);
         if (fire) begin
            finish    <= 1'b1;
            pass      <= (dut_done_code == EXIT_PASS);
            exit_code <= dut_done_code;
         end else if (timeout_hit) begin
            finish    <= 1'b1;
            pass      <= 1'b0;
            exit_code <= EXIT_TIMEOUT;
         end
      end
   end

`ifdef HARNESS_HEARTBEAT_EN
   logic [CNT_W-1:0] cnt_inc;

   assign cnt_inc = cycle_count + CNT_W'(1);

   // Pulse lines up with the cycle in which cycle_count shows the wrapped value.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         heartbeat <= 1'b0;
      end else begin
         heartbeat <= (state == RUN) && (state_next == RUN) && !cnt_sat &&
                      (cnt_inc[HB_LOG2-1:0] == '0);
      end
   end
`endif

endmodule

// File: tb/tb_sim_harness_ctrl.sv
// tb/tb_sim_harness_ctrl.sv - directed self-checking bench for sim_harness_ctrl
module tb_sim_harness_ctrl;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // main instance: default watchdog, 32-bit counter
   logic        rn_m = 1'b0, valid_m = 1'b0;
   logic [7:0]  code_m = 8'h00;
   logic        dr_m, rdy_m, fin_m, pass_m;
   logic [31:0] cc_m;
   logic [7:0]  ex_m;
   // watchdog instance: TIMEOUT_CYCLES=50
   logic        rn_t = 1'b0, valid_t = 1'b0;
   logic [7:0]  code_t = 8'h00;
   logic        dr_t, rdy_t, fin_t, pass_t;
   logic [31:0] cc_t;
   logic [7:0]  ex_t;
   // saturation instance: CNT_W=4, no watchdog
   logic        rn_s = 1'b0, valid_s = 1'b0;
   logic [7:0]  code_s = 8'h00;
   logic        dr_s, rdy_s, fin_s, pass_s;
   logic [3:0]  cc_s;
   logic [7:0]  ex_s;
`ifdef HARNESS_HEARTBEAT_EN
   logic hb_m, hb_t, hb_s;
`endif

   sim_harness_ctrl #(.RESET_CYCLES(5), .TIMEOUT_CYCLES(1000000), .CNT_W(32), .HB_LOG2(16)) u_main (
      .clock(clock), .reset_n(rn_m), .dut_reset(dr_m), .dut_done_valid(valid_m),
      .dut_done_code(code_m), .dut_done_ready(rdy_m), .cycle_count(cc_m),
      .finish(fin_m), .pass(pass_m), .exit_code(ex_m)
`ifdef HARNESS_HEARTBEAT_EN
      , .heartbeat(hb_m)
`endif
   );

   sim_harness_ctrl #(.RESET_CYCLES(5), .TIMEOUT_CYCLES(50), .CNT_W(32), .HB_LOG2(4)) u_to (
      .clock(clock), .reset_n(rn_t), .dut_reset(dr_t), .dut_done_valid(valid_t),
      .dut_done_code(code_t), .dut_done_ready(rdy_t), .cycle_count(cc_t),
      .finish(fin_t), .pass(pass_t), .exit_code(ex_t)
`ifdef HARNESS_HEARTBEAT_EN
      , .heartbeat(hb_t)
`endif
   );

   sim_harness_ctrl #(.RESET_CYCLES(5), .TIMEOUT_CYCLES(0), .CNT_W(4), .HB_LOG2(2)) u_sat (
      .clock(clock), .reset_n(rn_s), .dut_reset(dr_s), .dut_done_valid(valid_s),
      .dut_done_code(code_s), .dut_done_ready(rdy_s), .cycle_count(cc_s),
      .finish(fin_s), .pass(pass_s), .exit_code(ex_s)
`ifdef HARNESS_HEARTBEAT_EN
      , .heartbeat(hb_s)
`endif
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic restart_main();
      int n;
      rn_m = 1'b0;
      tick();
      tick();
      rn_m = 1'b1;
      n = 0;
      while (!rdy_m && n < 40) begin tick(); n++; end
      checks++;
      if (!rdy_m) begin errors++; $display("FAIL main_restart_ready: ready=%0b required 1 within 40 cycles", rdy_m); end
   endtask

   task automatic restart_to();
      int n;
      rn_t = 1'b0;
      tick();
      tick();
      rn_t = 1'b1;
      n = 0;
      while (!rdy_t && n < 40) begin tick(); n++; end
      checks++;
      if (!rdy_t) begin errors++; $display("FAIL to_restart_ready: ready=%0b required 1 within 40 cycles", rdy_t); end
   endtask

   task automatic test_reset();
      int n;
      repeat (3) tick();
      checks++; if (dr_m !== 1'b1)   begin errors++; $display("FAIL rst_dut_reset: got %0b want 1", dr_m); end
      checks++; if (rdy_m !== 1'b0)  begin errors++; $display("FAIL rst_ready: got %0b want 0", rdy_m); end
      checks++; if (fin_m !== 1'b0)  begin errors++; $display("FAIL rst_finish: got %0b want 0", fin_m); end
      checks++; if (pass_m !== 1'b0) begin errors++; $display("FAIL rst_pass: got %0b want 0", pass_m); end
      checks++; if (ex_m !== 8'h00)  begin errors++; $display("FAIL rst_exit_code: got %h want 00", ex_m); end
      checks++; if (cc_m !== 32'd0)  begin errors++; $display("FAIL rst_cycle_count: got %0d want 0", cc_m); end
      checks++; if (dr_s !== 1'b1)   begin errors++; $display("FAIL rst_sat_dut_reset: got %0b want 1", dr_s); end
      // one sample in the synchronizer plus RESET_CYCLES samples of HOLD
      rn_m = 1'b1;
      n = 0;
      tick();
      while (dr_m === 1'b1 && n < 40) begin n++; tick(); end
      checks++; if (n != 6)          begin errors++; $display("FAIL hold_length: dut_reset high for %0d samples want 6", n); end
      checks++; if (rdy_m !== 1'b1)  begin errors++; $display("FAIL run_ready: got %0b want 1", rdy_m); end
      checks++; if (cc_m !== 32'd0)  begin errors++; $display("FAIL run_first_count: got %0d want 0", cc_m); end
   endtask

   task automatic test_pass_code0();
      int n = 0;
      while (cc_m != 32'd100 && n < 300) begin tick(); n++; end
      checks++; if (cc_m !== 32'd100) begin errors++; $display("FAIL reach_100: got %0d want 100", cc_m); end
      valid_m = 1'b1;
      code_m  = 8'h00;
      tick();
      valid_m = 1'b0;
      checks++; if (fin_m !== 1'b1)    begin errors++; $display("FAIL pass_finish: got %0b want 1", fin_m); end
      checks++; if (pass_m !== 1'b1)   begin errors++; $display("FAIL pass_pass: got %0b want 1", pass_m); end
      checks++; if (ex_m !== 8'h00)    begin errors++; $display("FAIL pass_exit_code: got %h want 00", ex_m); end
      checks++; if (rdy_m !== 1'b0)    begin errors++; $display("FAIL pass_ready_drop: got %0b want 0", rdy_m); end
      checks++; if (dr_m !== 1'b0)     begin errors++; $display("FAIL pass_dut_reset: got %0b want 0", dr_m); end
      tick();
      checks++; if (cc_m !== 32'd101)  begin errors++; $display("FAIL pass_count_frozen: got %0d want 101", cc_m); end
   endtask

   task automatic test_fail_code();
      restart_main();
      repeat (3) tick();
      valid_m = 1'b1;
      code_m  = 8'h2A;
      tick();
      valid_m = 1'b0;
      checks++; if (fin_m !== 1'b1)   begin errors++; $display("FAIL code_finish: got %0b want 1", fin_m); end
      checks++; if (pass_m !== 1'b0)  begin errors++; $display("FAIL code_pass: got %0b want 0", pass_m); end
      checks++; if (ex_m !== 8'h2A)   begin errors++; $display("FAIL code_exit_code: got %h want 2a", ex_m); end
      valid_m = 1'b1;
      code_m  = 8'h00;
      repeat (3) tick();
      valid_m = 1'b0;
      tick();
      checks++; if (ex_m !== 8'h2A)   begin errors++; $display("FAIL sticky_exit_code: got %h want 2a", ex_m); end
      checks++; if (pass_m !== 1'b0)  begin errors++; $display("FAIL sticky_pass: got %0b want 0", pass_m); end
      checks++; if (rdy_m !== 1'b0)   begin errors++; $display("FAIL sticky_ready: got %0b want 0", rdy_m); end
   endtask

   task automatic test_timeout();
      int n = 0;
      logic [31:0] prev_cc = '0;
      restart_to();
      while (fin_t !== 1'b1 && n < 200) begin prev_cc = cc_t; tick(); n++; end
      checks++; if (n != 50)          begin errors++; $display("FAIL to_latency: finish after %0d cycles want 50", n); end
      checks++; if (prev_cc !== 32'd49) begin errors++; $display("FAIL to_last_count: got %0d want 49", prev_cc); end
      checks++; if (cc_t !== 32'd50)  begin errors++; $display("FAIL to_count: got %0d want 50", cc_t); end
      checks++; if (ex_t !== 8'hFF)   begin errors++; $display("FAIL to_exit_code: got %h want ff", ex_t); end
      checks++; if (pass_t !== 1'b0)  begin errors++; $display("FAIL to_pass: got %0b want 0", pass_t); end
      checks++; if (rdy_t !== 1'b0)   begin errors++; $display("FAIL to_ready: got %0b want 0", rdy_t); end
   endtask

   task automatic test_tie();
      int n = 0;
      restart_to();
      while (cc_t != 32'd49 && n < 200) begin tick(); n++; end
      checks++; if (cc_t !== 32'd49)  begin errors++; $display("FAIL tie_reach_49: got %0d want 49", cc_t); end
      valid_t = 1'b1;
      code_t  = 8'h00;
      tick();
      valid_t = 1'b0;
      checks++; if (fin_t !== 1'b1)   begin errors++; $display("FAIL tie_finish: got %0b want 1", fin_t); end
      checks++; if (pass_t !== 1'b1)  begin errors++; $display("FAIL tie_pass: got %0b want 1", pass_t); end
      checks++; if (ex_t !== 8'h00)   begin errors++; $display("FAIL tie_exit_code: got %h want 00", ex_t); end
   endtask

   task automatic test_reset_midrun();
      int n = 0;
      restart_main();
      checks++; if (fin_m !== 1'b0)   begin errors++; $display("FAIL mid_fresh_finish: got %0b want 0", fin_m); end
      while (cc_m != 32'd20 && n < 100) begin tick(); n++; end
      rn_m = 1'b0;
      #1;
      checks++; if (dr_m !== 1'b1)    begin errors++; $display("FAIL mid_dut_reset: got %0b want 1", dr_m); end
      checks++; if (cc_m !== 32'd0)   begin errors++; $display("FAIL mid_count: got %0d want 0", cc_m); end
      checks++; if (fin_m !== 1'b0)   begin errors++; $display("FAIL mid_finish: got %0b want 0", fin_m); end
      checks++; if (rdy_m !== 1'b0)   begin errors++; $display("FAIL mid_ready: got %0b want 0", rdy_m); end
   endtask

   task automatic test_saturation();
      int n = 0;
      rn_s = 1'b1;
      while (!rdy_s && n < 40) begin tick(); n++; end
      checks++; if (rdy_s !== 1'b1)   begin errors++; $display("FAIL sat_ready: got %0b want 1", rdy_s); end
      repeat (30) tick();
      checks++; if (cc_s !== 4'd15)   begin errors++; $display("FAIL sat_count: got %0d want 15", cc_s); end
      tick();
      checks++; if (cc_s !== 4'd15)   begin errors++; $display("FAIL sat_hold: got %0d want 15", cc_s); end
      checks++; if (fin_s !== 1'b0)   begin errors++; $display("FAIL sat_finish: got %0b want 0", fin_s); end
   endtask

   initial begin
      test_reset();
      test_pass_code0();
      test_fail_code();
      test_timeout();
      test_tie();
      test_reset_midrun();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
